address_range_router: RTL and testbench

- Registered request-routing stage that sits directly downstream of the static per-range address hit logic.
- Accepts one memory-mapped request per cycle on a valid/ready input.
- Decodes the address against NUM_RANGES fixed base/bound ranges and presents the request, rebased to a range-relative offset, on exactly one target's valid/ready channel.
- Requests that hit no range are consumed and reported on a one-cycle miss pulse.

---
 rtl/address_range_router.sv | 128 ++++++++++++
 tb/tb_address_range_router.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/address_range_router.sv
// Registered request router: decodes each accepted request against fixed
// base/bound ranges and presents it, rebased to a range-relative offset,
// on exactly one target channel through a one-entry output buffer.
// Requests that match no range produce a one-cycle miss pulse instead.
module address_range_router #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RANGES = 2,
  parameter logic [NUM_RANGES*ADDR_WIDTH-1:0] RANGE_BASES  = '0,
  parameter logic [NUM_RANGES*ADDR_WIDTH-1:0] RANGE_BOUNDS = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_write,
  output logic [NUM_RANGES-1:0] out_valid,
  input  logic [NUM_RANGES-1:0] out_ready,
  output logic [ADDR_WIDTH-1:0] out_offset,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_write,
  output logic                  miss,
  output logic [ADDR_WIDTH-1:0] miss_addr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q, state_d;
  logic [NUM_RANGES-1:0]   tgt_p1;
  logic [ADDR_WIDTH-1:0]   offset_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    write_p1;
  logic                    miss_p1;
  logic [ADDR_WIDTH-1:0]   miss_addr_p1;

  logic [NUM_RANGES-1:0]   hit;
  logic [ADDR_WIDTH-1:0]   range_off [NUM_RANGES];
  logic                    hit_any;
  logic [NUM_RANGES-1:0]   sel_oh;
  logic [ADDR_WIDTH-1:0]   sel_off;
  logic                    drain;
  logic                    accept;
  logic                    load;
  logic                    miss_d;

  // Stage p0: per-range compare. A one-bit-wider subtraction gives both the
  // unsigned comparison (borrow bit) and the rebased offset (low bits).
  for (genvar k = 0; k < NUM_RANGES; k++) begin : g_rng
    localparam logic [ADDR_WIDTH-1:0] BASE  = RANGE_BASES[k*ADDR_WIDTH +: ADDR_WIDTH];
    localparam logic [ADDR_WIDTH-1:0] BOUND = RANGE_BOUNDS[k*ADDR_WIDTH +: ADDR_WIDTH];
    logic [ADDR_WIDTH:0] lo_diff;
    logic [ADDR_WIDTH:0] hi_diff;
    assign lo_diff      = {1'b0, in_addr} - {1'b0, BASE};
    assign hi_diff      = {1'b0, BOUND} - {1'b0, in_addr};
    assign hit[k]       = !lo_diff[ADDR_WIDTH] && !hi_diff[ADDR_WIDTH];
    assign range_off[k] = lo_diff[ADDR_WIDTH-1:0];
  end

  // Priority select: scanning downward lets the lowest matching index win.
  always_comb begin
    hit_any = 1'b0;
    sel_oh  = '0;
    sel_off = '0;
    for (int k = NUM_RANGES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any   = 1'b1;
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        sel_off   = range_off[k];
      end
    end
  end

  // Handshake and next-state logic; out_ready reaches in_ready only via drain.
  always_comb begin
    out_valid = (state_q == FULL) ? tgt_p1 : '0;
    drain     = |(out_valid & out_ready);
    in_ready  = (state_q == EMPTY) || drain;
    accept    = in_valid && in_ready;
    load      = accept && hit_any;
    miss_d    = accept && !hit_any;
    state_d   = state_q;
    if (load) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // Stage p1 control: buffer state and miss reporting.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q      <= EMPTY;
      miss_p1      <= 1'b0;
      miss_addr_p1 <= '0;
    end else begin
      state_q <= state_d;
      miss_p1 <= miss_d;
      if (miss_d) begin
        miss_addr_p1 <= in_addr;
      end
    end
  end

  // Stage p1 payload: loaded only when a hitting request is accepted.
  always_ff @(posedge clock) begin
    if (clear) begin
      tgt_p1    <= '0;
      offset_p1 <= '0;
      data_p1   <= '0;
      write_p1  <= 1'b0;
    end else if (load) begin
      tgt_p1    <= sel_oh;
      offset_p1 <= sel_off;
      data_p1   <= in_data;
      write_p1  <= in_write;
    end
  end

  assign out_offset = offset_p1;
  assign out_data   = data_p1;
  assign out_write  = write_p1;
  assign miss       = miss_p1;
  assign miss_addr  = miss_addr_p1;

endmodule

// File: tb/tb_address_range_router.sv
// Directed bench for address_range_router: instance a uses disjoint ranges,
// instance b uses overlapping ranges to exercise lowest-index priority.
module tb_address_range_router;

  logic        clk = 1'b0;
  logic        clear;

  logic        a_in_valid, a_in_ready, a_in_write, a_out_write, a_miss;
  logic [7:0]  a_in_addr, a_out_offset, a_miss_addr;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_out_valid, a_out_ready;

  logic        b_in_valid, b_in_ready, b_in_write, b_out_write, b_miss;
  logic [7:0]  b_in_addr, b_out_offset, b_miss_addr;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_out_valid, b_out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  address_range_router #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_RANGES(2),
    .RANGE_BASES({8'h40, 8'h10}), .RANGE_BOUNDS({8'h7F, 8'h1F})
  ) dut_a (
    .clock(clk), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr),
    .in_data(a_in_data), .in_write(a_in_write),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_offset(a_out_offset),
    .out_data(a_out_data), .out_write(a_out_write),
    .miss(a_miss), .miss_addr(a_miss_addr)
  );

  address_range_router #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_RANGES(2),
    .RANGE_BASES({8'h20, 8'h00}), .RANGE_BOUNDS({8'h5F, 8'h3F})
  ) dut_b (
    .clock(clk), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr),
    .in_data(b_in_data), .in_write(b_in_write),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_offset(b_out_offset),
    .out_data(b_out_data), .out_write(b_out_write),
    .miss(b_miss), .miss_addr(b_miss_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear       = 1'b1;
    a_in_valid  = 1'b1;  a_in_addr = 8'h12;  a_in_data = 32'h0;  a_in_write = 1'b0;
    a_out_ready = 2'b11;
    b_in_valid  = 1'b0;  b_in_addr = 8'h00;  b_in_data = 32'h0;  b_in_write = 1'b0;
    b_out_ready = 2'b11;

    // Reset held two cycles with a valid hitting request on the input
    tick();
    tick();
    check("rst_out_valid", {30'd0, a_out_valid}, 32'h0);
    check("rst_miss", {31'd0, a_miss}, 32'h0);
    check("rst_miss_addr", {24'd0, a_miss_addr}, 32'h0);
    check("rst_offset", {24'd0, a_out_offset}, 32'h0);
    check("rst_data", a_out_data, 32'h0);
    check("rst_write", {31'd0, a_out_write}, 32'h0);
    clear      = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, a_in_ready}, 32'h1);
    tick();
    check("rst_no_xfer", {30'd0, a_out_valid}, 32'h0);

    // Range boundaries, back to back with both targets ready
    a_in_valid = 1'b1; a_in_addr = 8'h10; a_in_data = 32'hA1; a_in_write = 1'b1;
    tick();
    check("b0_valid", {30'd0, a_out_valid}, 32'h1);
    check("b0_offset", {24'd0, a_out_offset}, 32'h00);
    check("b0_data", a_out_data, 32'hA1);
    check("b0_write", {31'd0, a_out_write}, 32'h1);
    a_in_addr = 8'h1F; a_in_data = 32'hA2; a_in_write = 1'b0;
    #1;
    check("b1_in_ready", {31'd0, a_in_ready}, 32'h1);
    tick();
    check("b1_valid", {30'd0, a_out_valid}, 32'h1);
    check("b1_offset", {24'd0, a_out_offset}, 32'h0F);
    check("b1_data", a_out_data, 32'hA2);
    check("b1_write", {31'd0, a_out_write}, 32'h0);
    a_in_addr = 8'h40; a_in_data = 32'hA3;
    tick();
    check("b2_valid", {30'd0, a_out_valid}, 32'h2);
    check("b2_offset", {24'd0, a_out_offset}, 32'h00);
    a_in_addr = 8'h7F; a_in_data = 32'hA4;
    tick();
    check("b3_valid", {30'd0, a_out_valid}, 32'h2);
    check("b3_offset", {24'd0, a_out_offset}, 32'h3F);
    check("b3_data", a_out_data, 32'hA4);
    a_in_valid = 1'b0;
    tick();
    check("b_drained", {30'd0, a_out_valid}, 32'h0);
    check("b_no_miss", {31'd0, a_miss}, 32'h0);

    // Misses back to back
    a_in_valid = 1'b1; a_in_addr = 8'h20;
    tick();
    check("m0_pulse", {31'd0, a_miss}, 32'h1);
    check("m0_addr", {24'd0, a_miss_addr}, 32'h20);
    check("m0_no_valid", {30'd0, a_out_valid}, 32'h0);
    a_in_addr = 8'hFF;
    tick();
    check("m1_pulse", {31'd0, a_miss}, 32'h1);
    check("m1_addr", {24'd0, a_miss_addr}, 32'hFF);
    check("m1_no_valid", {30'd0, a_out_valid}, 32'h0);
    a_in_valid = 1'b0;
    tick();
    check("m_pulse_end", {31'd0, a_miss}, 32'h0);
    check("m_addr_held", {24'd0, a_miss_addr}, 32'hFF);

    // Backpressure: target 0 stalls for three cycles
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_addr = 8'h15; a_in_data = 32'hB1;
    tick();
    a_in_addr = 8'h50; a_in_data = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", {30'd0, a_out_valid}, 32'h1);
      check("bp_offset", {24'd0, a_out_offset}, 32'h05);
      check("bp_data", a_out_data, 32'hB1);
      check("bp_in_ready", {31'd0, a_in_ready}, 32'h0);
      if (i < 2) tick();
    end
    a_out_ready = 2'b01;
    #1;
    check("bp_release_ready", {31'd0, a_in_ready}, 32'h1);
    tick();
    check("bp_next_valid", {30'd0, a_out_valid}, 32'h2);
    check("bp_next_offset", {24'd0, a_out_offset}, 32'h10);
    check("bp_next_data", a_out_data, 32'hB2);
    a_in_valid = 1'b0;
    #1;
    check("bp_other_ready_ign", {31'd0, a_in_ready}, 32'h0);
    tick();
    check("bp_held_other", {30'd0, a_out_valid}, 32'h2);
    a_out_ready = 2'b10;
    tick();
    check("bp_drained", {30'd0, a_out_valid}, 32'h0);

    // Mid-operation reset with a stalled request
    a_out_ready = 2'b00;
    a_in_valid = 1'b1; a_in_addr = 8'h15; a_in_data = 32'hC1;
    tick();
    check("mr_full", {30'd0, a_out_valid}, 32'h1);
    a_in_valid = 1'b0;
    clear = 1'b1;
    tick();
    check("mr_cleared", {30'd0, a_out_valid}, 32'h0);
    check("mr_offset", {24'd0, a_out_offset}, 32'h0);
    clear = 1'b0;
    a_out_ready = 2'b11;
    tick();
    check("mr_gone", {30'd0, a_out_valid}, 32'h0);
    check("mr_in_ready", {31'd0, a_in_ready}, 32'h1);

    // Overlapping ranges on instance b
    b_in_valid = 1'b1; b_in_addr = 8'h30; b_in_data = 32'hD1; b_in_write = 1'b1;
    tick();
    check("ov_valid", {30'd0, b_out_valid}, 32'h1);
    check("ov_offset", {24'd0, b_out_offset}, 32'h30);
    b_in_addr = 8'h50;
    tick();
    check("ov_hi_valid", {30'd0, b_out_valid}, 32'h2);
    check("ov_hi_offset", {24'd0, b_out_offset}, 32'h30);
    b_in_addr = 8'h60;
    tick();
    check("ov_miss", {31'd0, b_miss}, 32'h1);
    check("ov_miss_addr", {24'd0, b_miss_addr}, 32'h60);
    check("ov_drained", {30'd0, b_out_valid}, 32'h0);
    b_in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
